// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Steps a 3-bit select value through 0..7 (or 7..0) to drive a 3-to-8 decoder.
// Each select value is held for dwell+1 cycles. The move to the next value is
// followed by a one-cycle blanking gap, during which the decoder is held in
// reset so that no two decoder outputs are ever active together. Every output
// comes straight from a flop.
//
// Parameters
//   DWELL_W   width of the dwell input
//
// Ports
//   clk       clock; all state changes happen on its rising edge
//   rst_n     asynchronous active-low reset
//   en        scan enable; when low the block parks in IDLE and holds a
//   dir       0 = ascending, 1 = descending (sampled only when a advances)
//   dwell     hold time per select value, in cycles minus one
//   load      single-cycle request to jump to load_val
//   load_val  jump target
//   a         select value (decoder address)
//   dec_rst   decoder blank, active high (1 forces all decoder outputs low)
//   step      one-cycle pulse on the first cycle of a newly advanced value
//   wrap      one-cycle pulse with step when the advance wrapped 7->0 or 0->7
//   busy      high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [2:0]         load_val,
    output logic [2:0]         a,
    output logic               dec_rst,
    output logic               step,
    output logic               wrap,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [2:0]         a_nxt;
    logic               step_nxt;
    logic               wrap_nxt;

    // Next-state logic. load wins over everything for the a update; en=0 then
    // wins over the normal state progression.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;

        if (load) begin
            a_nxt     = load_val;
            cnt_nxt   = '0;
            state_nxt = en ? BLANK : IDLE;
        end else if (!en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, BLANK: begin
                    // Every entry into DWELL reloads the full dwell count.
                    state_nxt = DWELL;
                    cnt_nxt   = dwell;
                end
                DWELL: begin
                    if (cnt == '0) begin
                        state_nxt = BLANK;
                        step_nxt  = 1'b1;
                        if (dir) begin
                            a_nxt    = a - 3'd1;
                            wrap_nxt = (a == 3'd0);
                        end else begin
                            a_nxt    = a + 3'd1;
                            wrap_nxt = (a == 3'd7);
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers. dec_rst and busy are registered copies of
    // decodes of the next state so they line up exactly with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a       <= 3'd0;
            dec_rst <= 1'b1;
            step    <= 1'b0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            a       <= a_nxt;
            dec_rst <= (state_nxt != DWELL);
            step    <= step_nxt;
            wrap    <= wrap_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

    localparam int DWELL_W = 8;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic               load;
    logic [2:0]         load_val;
    logic [2:0]         a;
    logic               dec_rst;
    logic               step;
    logic               wrap;
    logic               busy;

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .dwell    (dwell),
        .load     (load),
        .load_val (load_val),
        .a        (a),
        .dec_rst  (dec_rst),
        .step     (step),
        .wrap     (wrap),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the scan position, what the decoder is doing
    // (parked, showing a value, or blanked), and how many more cycles the
    // current value still has to be shown.
    // ------------------------------------------------------------------
    typedef struct {
        int a;
        int dec_rst;
        int step;
        int wrap;
        int busy;
    } exp_t;

    exp_t exp_q[$];

    int  m_pos;       // 0..7
    int  m_mode;      // 0 parked, 1 showing, 2 blanked gap
    int  m_left;      // further showing cycles after the current one
    int  m_step;
    int  m_wrap;

    function automatic void model_reset();
        m_pos  = 0;
        m_mode = 0;
        m_left = 0;
        m_step = 0;
        m_wrap = 0;
    endfunction

    function automatic void model_clock();
        int old_pos;
        m_step = 0;
        m_wrap = 0;
        if (load) begin
            m_pos  = int'(load_val);
            m_mode = en ? 2 : 0;
        end else if (!en) begin
            m_mode = 0;
        end else if (m_mode != 1) begin
            m_mode = 1;
            m_left = int'(dwell);
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            old_pos = m_pos;
            m_pos   = dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
            m_step  = 1;
            m_wrap  = (dir && old_pos == 0) || (!dir && old_pos == 7);
            m_mode  = 2;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.a       = m_pos;
        e.dec_rst = (m_mode != 1);
        e.step    = m_step;
        e.wrap    = m_wrap;
        e.busy    = (m_mode != 0);
        return e;
    endfunction

    // One clock: the model follows the inputs the DUT samples on this edge,
    // its expected outputs are queued, and control returns on the falling
    // edge so the caller can change inputs away from the active edge.
    task automatic cyc();
        @(posedge clk);
        model_clock();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Monitor: outputs are valid every cycle; compare one queued
    // expectation per clock, a little after the edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_a",       int'(a),       e.a);
            chk("sb_dec_rst", int'(dec_rst), e.dec_rst);
            chk("sb_step",    int'(step),    e.step);
            chk("sb_wrap",    int'(wrap),    e.wrap);
            chk("sb_busy",    int'(busy),    e.busy);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a"},       int'(a),       0);
        chk({tag, "_dec_rst"}, int'(dec_rst), 1);
        chk({tag, "_step"},    int'(step),    0);
        chk({tag, "_wrap"},    int'(wrap),    0);
        chk({tag, "_busy"},    int'(busy),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        dir      = 1'b0;
        dwell    = '0;
        load     = 1'b0;
        load_val = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Basic scan, dwell=2 ascending.
        en = 1'b1; dwell = 8'd2;
        cycles(3);
        chk("basic_dwell_a", int'(a), 0);
        chk("basic_dwell_dr", int'(dec_rst), 0);
        cyc();
        chk("basic_blank_a", int'(a), 1);
        chk("basic_blank_step", int'(step), 1);
        chk("basic_blank_dr", int'(dec_rst), 1);
        cycles(3);
        chk("basic_next_dr", int'(dec_rst), 0);
        chk("basic_next_a", int'(a), 1);

        // en drop on the second DWELL cycle at a=3, then re-enable.
        load = 1'b1; load_val = 3'd3; cyc(); load = 1'b0;
        cycles(2);
        en = 1'b0; cyc();
        chk("endrop_a", int'(a), 3);
        chk("endrop_dr", int'(dec_rst), 1);
        chk("endrop_busy", int'(busy), 0);
        en = 1'b1;
        cycles(3);
        chk("reen_a", int'(a), 3);
        chk("reen_dr", int'(dec_rst), 0);
        cyc();
        chk("reen_adv", int'(a), 4);

        // Load mid-DWELL with en=1, then with en=0.
        cycles(2);
        load = 1'b1; load_val = 3'd5; cyc(); load = 1'b0;
        chk("load_a", int'(a), 5);
        chk("load_dr", int'(dec_rst), 1);
        chk("load_step", int'(step), 0);
        chk("load_busy", int'(busy), 1);
        cycles(5);
        cycles(2);
        load = 1'b1; load_val = 3'd5; en = 1'b0; cyc(); load = 1'b0;
        chk("load_off_a", int'(a), 5);
        chk("load_off_busy", int'(busy), 0);
        en = 1'b1;

        // Wraps with minimum dwell.
        dwell = 8'd0;
        dir = 1'b0; load = 1'b1; load_val = 3'd7; cyc(); load = 1'b0;
        cycles(2);
        chk("wrap_up_a", int'(a), 0);
        chk("wrap_up_wrap", int'(wrap), 1);
        dir = 1'b1; load = 1'b1; load_val = 3'd0; cyc(); load = 1'b0;
        cycles(2);
        chk("wrap_dn_a", int'(a), 7);
        chk("wrap_dn_wrap", int'(wrap), 1);
        load = 1'b1; load_val = 3'd5; cyc(); load = 1'b0;
        cycles(2);
        chk("nowrap_a", int'(a), 4);
        chk("nowrap_step", int'(step), 1);
        chk("nowrap_wrap", int'(wrap), 0);

        // Minimum dwell ascending run.
        dir = 1'b0;
        cycles(12);

        // Asynchronous reset between edges while in BLANK.
        cycles(1);
        if (dec_rst !== 1'b1) cyc();
        chk("pre_async_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        #1 rst_n = 1'b1;
        cycles(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            dir      = $urandom_range(0, 1);
            dwell    = DWELL_W'($urandom_range(0, 3));
            load     = ($urandom_range(0, 14) == 0);
            load_val = 3'($urandom_range(0, 7));
            cyc();
        end
        load = 1'b0;
        en   = 1'b1;
        cycles(2);
        @(posedge clk);
        #4;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
